ahb3lite_master: RTL and testbench
==================================

AHB3LITE_MASTER -- requirements
Module: ahb3lite_master

Interface
REQ-001 Parameters SHALL be: HADDR_SIZE, default 16, address width; HDATA_SIZE, default 32, data width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: HCLK in 1 bus clock; HRESET in 1 async active-high reset.
REQ-003 Command ports SHALL be: cmd_valid in 1 command present; cmd_ready out 1 command accepted this edge; cmd_write in 1 write=1/read=0; cmd_addr in HADDR_SIZE byte address; cmd_size in 3 HSIZE code; cmd_wdata in HDATA_SIZE lane-aligned write data.
REQ-004 Response ports SHALL be: rsp_valid out 1 one-cycle completion pulse; rsp_write out 1 completed transfer was a write; rsp_rdata out HDATA_SIZE read data; rsp_err out 1 slave returned ERROR.
REQ-005 AHB ports SHALL be: HSEL out 1; HADDR out HADDR_SIZE; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HWDATA out HDATA_SIZE; HRDATA in HDATA_SIZE; HREADY in 1 (slave HREADYOUT); HRESP in 1.

Function
REQ-006 All AHB outputs SHALL be registered; every transfer SHALL be SINGLE (HBURST=3'b000), HPROT=4'b0011, HTRANS being IDLE (2'b00) or NONSEQ (2'b10) only.
REQ-007 cmd_ready SHALL equal HREADY AND NOT err_hold AND NOT retry_pend AND NOT HRESET (combinational).
REQ-008 On an edge with cmd_valid&&cmd_ready, address-phase registers SHALL load: HADDR=cmd_addr, HWRITE=cmd_write, HSIZE=cmd_size, HTRANS=NONSEQ, HSEL=1.
REQ-009 On an edge with HREADY=1 and no command accepted and no retry pending, HTRANS SHALL become IDLE and HSEL 0; HADDR/HWRITE/HSIZE SHALL hold.
REQ-010 While HREADY=0, address-phase outputs SHALL hold, except the error cancel of REQ-014.
REQ-011 On an edge with HREADY=1 and HTRANS=NONSEQ, the transfer SHALL move to the data phase: dp_valid=1, dp_write=HWRITE, and for writes HWDATA=the wdata captured with that command, so HWDATA is valid exactly one cycle after its address phase and held while HREADY=0.
REQ-012 Back-to-back commands SHALL pipeline with zero bubbles: address phase N+1 overlaps data phase N.
REQ-013 In a cycle with dp_valid=1 and HREADY=1, rsp_valid SHALL pulse for one cycle (registered, next cycle) with rsp_rdata=HRDATA (0 for writes), rsp_write=dp_write, rsp_err=HRESP; no response backpressure exists.
REQ-014 Two-cycle ERROR: in the first cycle (HRESP=1, HREADY=0, dp_valid=1), err_hold SHALL set; if HTRANS=NONSEQ that address phase SHALL be saved to a retry register and HTRANS driven IDLE at the next edge (cancel).
REQ-015 In the second ERROR cycle (HRESP=1, HREADY=1), the errored transfer SHALL complete per REQ-013 with rsp_err=1 and err_hold SHALL clear.
REQ-016 A saved retry SHALL be re-issued as NONSEQ on the edge after the ERROR completes, before any new command; cmd_ready SHALL stay 0 until that re-issue is accepted (HREADY=1).
REQ-017 A response SHALL be produced exactly once per accepted command, in acceptance order.
REQ-018 HRESP=1 with dp_valid=0 SHALL be ignored.

Reset
REQ-019 While HRESET=1 (asynchronously): HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=4'b0011, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, dp_valid=0, err_hold=0, retry register cleared, cmd_ready=0.
REQ-020 Reset asserted mid-transfer SHALL discard all in-flight and retry state without emitting a response; the first command after deassertion SHALL appear as NONSEQ one edge after acceptance.

Verification
REQ-021 Single write: cmd write addr 0x0010 data 0xDEADBEEF, HREADY=1 -> NONSEQ at 0x0010 one cycle, HWDATA=0xDEADBEEF next cycle, rsp_valid with rsp_err=0 one cycle later.
REQ-022 Back-to-back: write 0x0004=0x11111111, then read 0x0004 on consecutive cycles -> HTRANS NONSEQ,NONSEQ with no IDLE gap; read rsp_rdata=0x11111111.
REQ-023 Wait states: slave holds HREADY=0 two cycles in a write data phase -> HADDR/HTRANS of the following read and HWDATA unchanged for those two cycles; cmd_ready=0 throughout.
REQ-024 Error with pending read: HRESP ERROR on write to 0x00F0 while read 0x0008 is in address phase -> HTRANS IDLE in second error cycle, rsp_err=1 for the write, read re-issued NONSEQ at 0x0008 next and completes with rsp_err=0.
REQ-025 Reset mid-operation: assert HRESET during a wait-stated read -> all outputs at REQ-019 values immediately, no rsp_valid; after release, a new write completes normally.
REQ-026 Idle: cmd_valid=0 for 10 cycles -> HTRANS=IDLE, HSEL=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/ahb3lite_master.sv
// AHB3-Lite single-transfer master: command in, response out, fully pipelined
// address/data phases with two-cycle ERROR handling and address-phase retry.
module ahb3lite_master #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_NONSEQ = 2'b10} htrans_e;

  htrans_e               htrans_q, htrans_d;
  logic                  hsel_q, hsel_d;
  logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [HDATA_SIZE-1:0] ap_wdata_q, ap_wdata_d;
  logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic                  err_hold_q, err_hold_d;
  logic                  retry_pend_q, retry_pend_d;
  logic [HADDR_SIZE-1:0] rt_addr_q, rt_addr_d;
  logic                  rt_write_q, rt_write_d;
  logic [2:0]            rt_size_q, rt_size_d;
  logic [HDATA_SIZE-1:0] rt_wdata_q, rt_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic err_first;

  assign cmd_ready = HREADY & ~err_hold_q & ~retry_pend_q & ~HRESET;
  assign accept    = cmd_valid & cmd_ready;
  assign err_first = HRESP & ~HREADY & dp_valid_q;

  always_comb begin
    htrans_d     = htrans_q;
    hsel_d       = hsel_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    ap_wdata_d   = ap_wdata_q;
    hwdata_d     = hwdata_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    err_hold_d   = err_hold_q;
    retry_pend_d = retry_pend_q;
    rt_addr_d    = rt_addr_q;
    rt_write_d   = rt_write_q;
    rt_size_d    = rt_size_q;
    rt_wdata_d   = rt_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_write_d  = rsp_write_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;

    if (err_first) begin
      // First ERROR cycle: park any pending address phase and drop it from the bus
      err_hold_d = 1'b1;
      if (htrans_q == TR_NONSEQ) begin
        retry_pend_d = 1'b1;
        rt_addr_d    = haddr_q;
        rt_write_d   = hwrite_q;
        rt_size_d    = hsize_q;
        rt_wdata_d   = ap_wdata_q;
        htrans_d     = TR_IDLE;
        hsel_d       = 1'b0;
      end
    end else if (HREADY) begin
      err_hold_d = 1'b0;

      dp_valid_d = (htrans_q == TR_NONSEQ);
      if (htrans_q == TR_NONSEQ) begin
        dp_write_d = hwrite_q;
        if (hwrite_q) hwdata_d = ap_wdata_q;
      end

      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = dp_write_q;
        rsp_err_d   = HRESP;
        rsp_rdata_d = dp_write_q ? '0 : HRDATA;
      end

      if (retry_pend_q) begin
        retry_pend_d = 1'b0;
        htrans_d     = TR_NONSEQ;
        hsel_d       = 1'b1;
        haddr_d      = rt_addr_q;
        hwrite_d     = rt_write_q;
        hsize_d      = rt_size_q;
        ap_wdata_d   = rt_wdata_q;
      end else if (accept) begin
        htrans_d   = TR_NONSEQ;
        hsel_d     = 1'b1;
        haddr_d    = cmd_addr;
        hwrite_d   = cmd_write;
        hsize_d    = cmd_size;
        ap_wdata_d = cmd_wdata;
      end else begin
        htrans_d = TR_IDLE;
        hsel_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      htrans_q     <= TR_IDLE;
      hsel_q       <= 1'b0;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      ap_wdata_q   <= '0;
      hwdata_q     <= '0;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      err_hold_q   <= 1'b0;
      retry_pend_q <= 1'b0;
      rt_addr_q    <= '0;
      rt_write_q   <= 1'b0;
      rt_size_q    <= '0;
      rt_wdata_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      htrans_q     <= htrans_d;
      hsel_q       <= hsel_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      ap_wdata_q   <= ap_wdata_d;
      hwdata_q     <= hwdata_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      err_hold_q   <= err_hold_d;
      retry_pend_q <= retry_pend_d;
      rt_addr_q    <= rt_addr_d;
      rt_write_q   <= rt_write_d;
      rt_size_q    <= rt_size_d;
      rt_wdata_q   <= rt_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign HTRANS    = htrans_q;
  assign HSEL      = hsel_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb3lite_master.sv
// Self-checking bench for ahb3lite_master: small memory slave, response
// scoreboard, and per-scenario checks of the AHB address/data phases.
module tb_ahb3lite_master;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          HSEL, HWRITE, HREADY, HRESP;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA, HRDATA;

  always #5 HCLK = ~HCLK;

  ahb3lite_master #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          w;
    logic          e;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [DW-1:0] shadow [0:255];
  logic [DW-1:0] mem [0:255];
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic          rs;

  // Memory slave: tracks its own data phase from the bus, skips stores on ERROR
  logic          sl_act, sl_write;
  logic [AW-1:0] sl_addr;
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sl_act <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | i;
    end else if (HREADY) begin
      if (sl_act && sl_write && !HRESP) mem[sl_addr[9:2]] <= HWDATA;
      sl_act   <= (HTRANS == 2'b10);
      sl_addr  <= HADDR;
      sl_write <= HWRITE;
    end
  end
  assign HRDATA = (sl_act && !sl_write) ? mem[sl_addr[9:2]] : '0;

  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected act_write=%0b act_err=%0b act_rdata=%h", rsp_write, rsp_err, rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_write !== mon_e.w || rsp_err !== mon_e.e || rsp_rdata !== mon_e.d) begin
          failures++;
          $display("FAIL rsp_content act w=%0b e=%0b d=%h exp w=%0b e=%0b d=%h",
                   rsp_write, rsp_err, rsp_rdata, mon_e.w, mon_e.e, mon_e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic init_shadow();
    for (int i = 0; i < 256; i++) shadow[i] = 32'hC0DE0000 | i;
  endtask

  // Drives one cycle of stimulus from a negedge and returns at the next negedge.
  task automatic step(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rdy, input logic resp, output logic rdy_seen);
    exp_t e;
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = 3'b010; cmd_wdata = d;
    HREADY = rdy; HRESP = resp;
    #1;
    rdy_seen = cmd_ready;
    if (v && cmd_ready) begin
      e.w = w;
      e.e = err_en && (a == err_addr);
      if (w) begin
        e.d = '0;
        if (!e.e) shadow[a[9:2]] = d;
      end else begin
        e.d = shadow[a[9:2]];
      end
      sb.push_back(e);
    end
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    init_shadow();
    sb.delete();
    repeat (2) @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans act=%h exp=00", HTRANS); end
    checks++; if (HSEL !== 1'b0) begin failures++; $display("FAIL rst_hsel act=%b exp=0", HSEL); end
    checks++; if (HADDR !== 16'h0000) begin failures++; $display("FAIL rst_haddr act=%h exp=0000", HADDR); end
    checks++; if (HWRITE !== 1'b0 || HSIZE !== 3'b000) begin failures++; $display("FAIL rst_hwrite_hsize act=%b/%h exp=0/0", HWRITE, HSIZE); end
    checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin failures++; $display("FAIL rst_burst_prot act=%h/%h exp=0/3", HBURST, HPROT); end
    checks++; if (HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata act=%h exp=0", HWDATA); end
    checks++; if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_rsp act=%b%b%b/%h exp=000/0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready act=%b exp=0", cmd_ready); end
    HRESET = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready act=%b exp=1", cmd_ready); end
    @(negedge HCLK);
  endtask

  task automatic test_single_write();
    step(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin failures++; $display("FAIL sw_ap_trans act=%h/%b exp=2/1", HTRANS, HSEL); end
    checks++; if (HADDR !== 16'h0010 || HWRITE !== 1'b1 || HSIZE !== 3'b010) begin
      failures++; $display("FAIL sw_ap_ctrl act=%h/%b/%h exp=0010/1/2", HADDR, HWRITE, HSIZE); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (HWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_hwdata act=%h exp=deadbeef", HWDATA); end
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 16'h0010) begin
      failures++; $display("FAIL sw_idle_after act=%h/%b/%h exp=0/0/0010", HTRANS, HSEL, HADDR); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sw_rsp_early act=%b exp=0", rsp_valid); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL sw_rsp_valid act=%b exp=1", rsp_valid); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sw_rsp_pulse act=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 16'h0004, 32'h11111111, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0004 || HWRITE !== 1'b1) begin
      failures++; $display("FAIL b2b_ap1 act=%h/%h/%b exp=2/0004/1", HTRANS, HADDR, HWRITE); end
    step(1'b1, 1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0004 || HWRITE !== 1'b0) begin
      failures++; $display("FAIL b2b_ap2 act=%h/%h/%b exp=2/0004/0", HTRANS, HADDR, HWRITE); end
    checks++; if (HWDATA !== 32'h11111111) begin failures++; $display("FAIL b2b_hwdata act=%h exp=11111111", HWDATA); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin
      failures++; $display("FAIL b2b_wr_rsp act=%h/%b/%b exp=0/1/1", HTRANS, rsp_valid, rsp_write); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin
      failures++; $display("FAIL b2b_rd_rsp act=%b/%h exp=1/11111111", rsp_valid, rsp_rdata); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
  endtask

  task automatic test_wait_states();
    step(1'b1, 1'b1, 16'h0020, 32'hA5A5A5A5, 1'b1, 1'b0, rs);
    step(1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0020 || HWRITE !== 1'b0 || HWDATA !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL ws_start act=%h/%h/%b/%h exp=2/0020/0/a5a5a5a5", HTRANS, HADDR, HWRITE, HWDATA); end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, rs);
      checks++; if (rs !== 1'b0) begin failures++; $display("FAIL ws_cmd_ready cyc=%0d act=%b exp=0", k, rs); end
      checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0020 || HWRITE !== 1'b0 || HWDATA !== 32'hA5A5A5A5) begin
        failures++; $display("FAIL ws_hold cyc=%0d act=%h/%h/%b/%h exp=2/0020/0/a5a5a5a5", k, HTRANS, HADDR, HWRITE, HWDATA); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ws_rsp cyc=%0d act=%b exp=0", k, rsp_valid); end
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || HTRANS !== 2'b00) begin
      failures++; $display("FAIL ws_wr_done act=%b/%b/%h exp=1/1/0", rsp_valid, rsp_write, HTRANS); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL ws_rd_done act=%b/%h exp=1/a5a5a5a5", rsp_valid, rsp_rdata); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
  endtask

  task automatic test_error_retry();
    err_en = 1'b1; err_addr = 16'h00F0;
    step(1'b1, 1'b1, 16'h00F0, 32'hBAD0BAD0, 1'b1, 1'b0, rs);
    step(1'b1, 1'b0, 16'h0008, 32'h0, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0008 || HWDATA !== 32'hBAD0BAD0) begin
      failures++; $display("FAIL err_setup act=%h/%h/%h exp=2/0008/bad0bad0", HTRANS, HADDR, HWDATA); end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rs);
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin failures++; $display("FAIL err_cancel act=%h/%b exp=0/0", HTRANS, HSEL); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL err_rsp_early act=%b exp=0", rsp_valid); end
    step(1'b1, 1'b1, 16'h000C, 32'h77777777, 1'b1, 1'b1, rs);
    checks++; if (rs !== 1'b0) begin failures++; $display("FAIL err_cmd_ready act=%b exp=0", rs); end
    checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0008 || HWRITE !== 1'b0) begin
      failures++; $display("FAIL err_reissue act=%h/%h/%b exp=2/0008/0", HTRANS, HADDR, HWRITE); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== 1'b1) begin
      failures++; $display("FAIL err_rsp act=%b/%b/%b exp=1/1/1", rsp_valid, rsp_err, rsp_write); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin failures++; $display("FAIL err_gap act=%h/%b exp=0/0", HTRANS, rsp_valid); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hC0DE0002) begin
      failures++; $display("FAIL err_retry_rsp act=%b/%b/%h exp=1/0/c0de0002", rsp_valid, rsp_err, rsp_rdata); end
    err_en = 1'b0;
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0, (i % 3) != 0, (i >= 3 && i <= 5), rs);
      checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || rsp_valid !== 1'b0) begin
        failures++; $display("FAIL idle cyc=%0d act=%h/%b/%b exp=0/0/0", i, HTRANS, HSEL, rsp_valid); end
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rs !== 1'b1) begin failures++; $display("FAIL idle_hresp_ignored act=%b exp=1", rs); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 16'h0008, 32'h0, 1'b1, 1'b0, rs);
    step(1'b0, 1'b1, 16'h0044, 32'h0, 1'b1, 1'b0, rs);
    HREADY = 1'b0;
    HRESET = 1'b1;
    #1;
    sb.delete();
    init_shadow();
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 16'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b0) begin
      failures++; $display("FAIL rm_addr_phase act=%h/%b/%h/%b/%h exp=0/0/0/0/0", HTRANS, HSEL, HADDR, HWRITE, HSIZE); end
    checks++; if (HWDATA !== 32'h0 || HPROT !== 4'b0011 || HBURST !== 3'b0) begin
      failures++; $display("FAIL rm_data act=%h/%h/%h exp=0/3/0", HWDATA, HPROT, HBURST); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL rm_rsp act=%b/%h/%b exp=0/0/0", rsp_valid, rsp_rdata, cmd_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_no_rsp cyc=%0d act=%b exp=0", k, rsp_valid); end
    end
    HRESET = 1'b0;
    step(1'b1, 1'b1, 16'h0030, 32'h12345678, 1'b1, 1'b0, rs);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0030 || HSEL !== 1'b1) begin
      failures++; $display("FAIL rm_new_ap act=%h/%h/%b exp=2/0030/1", HTRANS, HADDR, HSEL); end
    step(1'b1, 1'b0, 16'h0030, 32'h0, 1'b1, 1'b0, rs);
    checks++; if (HWDATA !== 32'h12345678) begin failures++; $display("FAIL rm_new_hwdata act=%h exp=12345678", HWDATA); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin failures++; $display("FAIL rm_new_rsp act=%b/%b exp=1/0", rsp_valid, rsp_err); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rs);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL drain pending act=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_error_retry();
    test_idle();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
